// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
// Optional subtract support is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_e;

  typedef struct packed {
    logic [31:0] n;
    logic [31:0] cw;
  } sa_geom_t;

  // Digit steps per operation and the counter width needed to index them
  function automatic sa_geom_t sa_geom(input int unsigned width, input int unsigned digit);
    sa_geom_t g;
    g.n  = (digit == 32'd0) ? 32'd1 : width / digit;
    g.cw = (g.n > 32'd1) ? 32'($clog2(g.n)) : 32'd1;
    return g;
  endfunction

  function automatic bit sa_params_ok(input int unsigned width, input int unsigned digit);
    return (width >= 32'd2) && (digit != 32'd0) && ((width % digit) == 32'd0);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder; the sub field exists
// only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
endinterface

// File: rtl/serial_adder_digit.sv
// Combinational DIGIT-bit ripple slice; also exposes the carry into its MSB
// so the top level can derive signed overflow on the final digit.
module serial_adder_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);
  logic [DIGIT:0] c_s;

  // Bit-by-bit ripple through the slice
  always_comb begin
    c_s    = '0;
    sum    = '0;
    c_s[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (a[i] & c_s[i]) | (b[i] & c_s[i]);
    end
  end

  assign cout = c_s[DIGIT];
  assign cmsb = c_s[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// Digit-serial two's-complement adder, DIGIT bits per clock, one operation
// in flight. Subtract mode is built in when SERIAL_ADDER_SUB_EN is defined.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic           ck,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam sa_geom_t      GEOM = sa_geom(WIDTH, DIGIT);
  localparam int            N    = int'(GEOM.n);
  localparam int            CW   = int'(GEOM.cw);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!sa_params_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  sa_state_e        state_r, state_s;
  logic             in_ready_r, in_ready_s, out_valid_r, out_valid_s;
  logic [WIDTH-1:0] a_r, b_r, s_r, s_next_s;
  logic             carry_r, co_r, ovf_r, sub_r, sub_s, accept_s;
  logic [CW-1:0]    cnt_r;
  logic [DIGIT-1:0] dsum_s;
  logic             dcout_s, dcmsb_s;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_s = bus.sub;
`else
  assign sub_s = 1'b0;
`endif

  assign accept_s = bus.in_valid & in_ready_r;

  serial_adder_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_r[DIGIT-1:0]),
    .b    (b_r[DIGIT-1:0]),
    .cin  (carry_r),
    .sum  (dsum_s),
    .cout (dcout_s),
    .cmsb (dcmsb_s)
  );

  // New digits enter at the top so the LSB digit lands at bit 0 after N steps
  if (DIGIT == WIDTH) begin : g_one_step
    assign s_next_s = dsum_s;
  end else begin : g_multi_step
    assign s_next_s = {dsum_s, s_r[WIDTH-1:DIGIT]};
  end

  // State register
  always_ff @(posedge ck) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_s = RUN; else state_s = IDLE;
      RUN:     if (cnt_r == LAST) state_s = DONE; else state_s = RUN;
      DONE:    if (out_valid_r && bus.out_ready) state_s = IDLE; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state, registered below
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_s)
      IDLE:    in_ready_s  = 1'b1;
      DONE:    out_valid_s = 1'b1;
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Handshake output flops; held low through reset
  always_ff @(posedge ck) begin
    if (rst) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

  // Operand shifters, carry, digit counter and result capture
  always_ff @(posedge ck) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      s_r     <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      co_r    <= 1'b0;
      ovf_r   <= 1'b0;
      sub_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: if (accept_s) begin
          a_r     <= bus.a;
          b_r     <= sub_s ? ~bus.b : bus.b;
          carry_r <= bus.ci ^ sub_s;
          cnt_r   <= '0;
          sub_r   <= sub_s;
        end
        RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          s_r     <= s_next_s;
          carry_r <= dcout_s;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == LAST) begin
            // A subtract reports borrow, the complement of the final carry
            co_r  <= dcout_s ^ sub_r;
            ovf_r <= dcout_s ^ dcmsb_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.s         = s_r;
  assign bus.co        = co_r;
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: two instances (DIGIT=1 and DIGIT=4),
// arithmetic reference model, decoupled result monitors.
module tb_serial_adder;
  logic ck = 1'b0;
  logic rst;
  always #5 ck = ~ck;

  serial_adder_if #(.WIDTH(8)) ifc0 ();
  serial_adder_if #(.WIDTH(8)) ifc1 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (.ck(ck), .rst(rst), .bus(ifc0));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u1 (.ck(ck), .rst(rst), .bus(ifc1));

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ovf;
  } res_t;

  res_t exp_q0[$];
  res_t exp_q1[$];
  int   lat_q0[$];
  int   lat_q1[$];
  res_t e0, e1, bp;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc, prev_acc;
  bit   rand_or = 1'b0;
  logic ov0_prev = 1'b0;
  logic ov1_prev = 1'b0;

  always @(posedge ck) cyc <= cyc + 1;

  // Reference: exact integer arithmetic, then reduce modulo 2^8
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic ci, input logic sub);
    res_t r;
    int   ur, sr;
    if (sub) begin
      ur   = int'(a) - int'(b) - int'(ci);
      sr   = int'($signed(a)) - int'($signed(b)) - int'(ci);
      r.co = (ur < 0);
    end else begin
      ur   = int'(a) + int'(b) + int'(ci);
      sr   = int'($signed(a)) + int'($signed(b)) + int'(ci);
      r.co = (ur > 255);
    end
    r.s   = ur[7:0];
    r.ovf = (sr > 127) || (sr < -128);
    return r;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endfunction

  function automatic void fail(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", nm);
  endfunction

  function automatic logic rsub();
`ifdef SERIAL_ADDER_SUB_EN
    return 1'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  // Present operands from a negedge, wait for the handshake, log expectation
  task automatic send(input int u, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic sub, output int acc_cyc);
    bit ok = 1'b0;
    acc_cyc = -1;
    if (u == 0) begin
      ifc0.a = a; ifc0.b = b; ifc0.ci = ci; ifc0.in_valid = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
      ifc0.sub = sub;
`endif
    end else begin
      ifc1.a = a; ifc1.b = b; ifc1.ci = ci; ifc1.in_valid = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
      ifc1.sub = sub;
`endif
    end
    for (int k = 0; k < 200 && !ok; k++) begin
      if (rand_or && u == 0) ifc0.out_ready = 1'($urandom_range(0, 1));
      if ((u == 0) ? ifc0.in_ready : ifc1.in_ready) begin
        @(posedge ck);
        @(negedge ck);
        ok = 1'b1;
        acc_cyc = cyc;
        if (u == 0) begin
          exp_q0.push_back(model(a, b, ci, sub));
          lat_q0.push_back(acc_cyc);
        end else begin
          exp_q1.push_back(model(a, b, ci, sub));
          lat_q1.push_back(acc_cyc);
        end
      end else begin
        @(negedge ck);
      end
    end
    if (!ok) fail("send_timeout");
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0 && ifc0.in_ready && ifc1.in_ready) ok = 1'b1;
      else @(negedge ck);
    end
    if (!ok) fail("drain_timeout");
  endtask

  // Monitor for the DIGIT=1 instance
  always @(negedge ck) begin
    if (ifc0.out_valid && !ov0_prev) begin
      if (lat_q0.size() == 0) fail("u0_spurious_valid");
      else chk("u0_latency", cyc - lat_q0.pop_front(), 32'd8);
    end
    if (ifc0.out_valid && ifc0.out_ready) begin
      if (exp_q0.size() == 0) fail("u0_unexpected_result");
      else begin
        e0 = exp_q0.pop_front();
        chk("u0_s", ifc0.s, e0.s);
        chk("u0_co", ifc0.co, e0.co);
        chk("u0_ovf", ifc0.ovf, e0.ovf);
      end
    end
    ov0_prev = ifc0.out_valid;
  end

  // Monitor for the DIGIT=4 instance
  always @(negedge ck) begin
    if (ifc1.out_valid && !ov1_prev) begin
      if (lat_q1.size() == 0) fail("u1_spurious_valid");
      else chk("u1_latency", cyc - lat_q1.pop_front(), 32'd2);
    end
    if (ifc1.out_valid && ifc1.out_ready) begin
      if (exp_q1.size() == 0) fail("u1_unexpected_result");
      else begin
        e1 = exp_q1.pop_front();
        chk("u1_s", ifc1.s, e1.s);
        chk("u1_co", ifc1.co, e1.co);
        chk("u1_ovf", ifc1.ovf, e1.ovf);
      end
    end
    ov1_prev = ifc1.out_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifc0.in_valid = 1'b0; ifc0.out_ready = 1'b0; ifc0.a = '0; ifc0.b = '0; ifc0.ci = 1'b0;
    ifc1.in_valid = 1'b0; ifc1.out_ready = 1'b0; ifc1.a = '0; ifc1.b = '0; ifc1.ci = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    ifc0.sub = 1'b0; ifc1.sub = 1'b0;
`endif
    repeat (3) @(negedge ck);
    chk("rst_in_ready0", ifc0.in_ready, 32'd0);
    chk("rst_in_ready1", ifc1.in_ready, 32'd0);
    chk("rst_out_valid", ifc0.out_valid, 32'd0);
    chk("rst_s", ifc0.s, 32'd0);
    chk("rst_co", ifc0.co, 32'd0);
    chk("rst_ovf", ifc0.ovf, 32'd0);
    rst = 1'b0;
    @(negedge ck);
    chk("post_rst_in_ready0", ifc0.in_ready, 32'd1);
    chk("post_rst_in_ready1", ifc1.in_ready, 32'd1);
    ifc0.out_ready = 1'b1;
    ifc1.out_ready = 1'b1;

    send(0, 8'h5A, 8'h33, 1'b0, 1'b0, acc); ifc0.in_valid = 1'b0;
    send(1, 8'hFF, 8'h01, 1'b1, 1'b0, acc); ifc1.in_valid = 1'b0;
    wait_idle();

    // Backpressure: result must sit unchanged while out_ready is low
    ifc0.out_ready = 1'b0;
    bp = model(8'hC3, 8'h7E, 1'b1, 1'b0);
    send(0, 8'hC3, 8'h7E, 1'b1, 1'b0, acc); ifc0.in_valid = 1'b0;
    for (int k = 0; k < 50 && !ifc0.out_valid; k++) @(negedge ck);
    if (!ifc0.out_valid) fail("bp_wait_valid");
    for (int i = 0; i < 5; i++) begin
      ifc0.in_valid = 1'b1;
      ifc0.a = 8'($urandom);
      chk("bp_out_valid", ifc0.out_valid, 32'd1);
      chk("bp_s", ifc0.s, bp.s);
      chk("bp_co", ifc0.co, bp.co);
      chk("bp_ovf", ifc0.ovf, bp.ovf);
      chk("bp_in_ready", ifc0.in_ready, 32'd0);
      @(negedge ck);
    end
    ifc0.in_valid = 1'b0;
    ifc0.out_ready = 1'b1;
    wait_idle();

    // Reset in the third RUN cycle discards the operation
    send(0, 8'h77, 8'h10, 1'b0, 1'b0, acc); ifc0.in_valid = 1'b0;
    repeat (2) @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
    chk("mid_rst_out_valid", ifc0.out_valid, 32'd0);
    chk("mid_rst_s", ifc0.s, 32'd0);
    chk("mid_rst_in_ready", ifc0.in_ready, 32'd0);
    void'(exp_q0.pop_back());
    void'(lat_q0.pop_back());
    rst = 1'b0;
    @(negedge ck);
    chk("mid_rst_in_ready_after", ifc0.in_ready, 32'd1);
    send(0, 8'h01, 8'h01, 1'b0, 1'b0, acc); ifc0.in_valid = 1'b0;
    wait_idle();

`ifdef SERIAL_ADDER_SUB_EN
    send(0, 8'h10, 8'h20, 1'b0, 1'b1, acc); ifc0.in_valid = 1'b0;
    send(1, 8'h80, 8'h01, 1'b0, 1'b1, acc); ifc1.in_valid = 1'b0;
    wait_idle();
`endif

    // Streaming with in_valid and out_ready held high
    prev_acc = -1;
    for (int i = 0; i < 4; i++) begin
      send(0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), rsub(), acc);
      if (i > 0) chk("stream_spacing", acc - prev_acc, 32'd10);
      prev_acc = acc;
    end
    ifc0.in_valid = 1'b0;
    wait_idle();

    // Random traffic with random consumer stalls on u0
    rand_or = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), rsub(), acc);
      ifc0.in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge ck);
    end
    rand_or = 1'b0;
    ifc0.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), rsub(), acc);
      ifc1.in_valid = 1'b0;
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
